// File: rtl/rcv_fifo_pkg.sv
// Shared types and helpers for the UART receive FIFO.
package rcv_fifo_pkg;

    localparam int unsigned RCV_DATA_W = 8;
    localparam int unsigned PTR_MAX_W  = 32;

    typedef struct packed {
        logic                  frame_err;
        logic [RCV_DATA_W-1:0] data;
    } rcv_entry_t;

    // Advance a {tog, idx} pointer: idx wraps to zero and tog inverts on wrap.
    function automatic logic [PTR_MAX_W-1:0] ptr_inc(
        input logic [PTR_MAX_W-1:0] ptr,
        input int unsigned          addr_w
    );
        logic [PTR_MAX_W-1:0] idx_max;
        logic [PTR_MAX_W-1:0] idx;
        logic                 tog;
        logic [PTR_MAX_W-1:0] res;
        idx_max = (32'd1 << addr_w) - 32'd1;
        idx     = ptr & idx_max;
        tog     = ptr[addr_w];
        if (idx == idx_max) begin
            idx = 32'd0;
            tog = ~tog;
        end else begin
            idx = idx + 32'd1;
        end
        res         = idx;
        res[addr_w] = tog;
        return res;
    endfunction

endpackage

// File: rtl/rcv_fifo_flags.sv
// Occupancy count and status flags derived purely from the registered
// head/tail pointers.
module rcv_fifo_flags
    import rcv_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = 2
) (
    input  logic [ADDR_W:0] head_i,
    input  logic [ADDR_W:0] tail_i,
    input  logic [ADDR_W:0] af_level_i,
    input  logic [ADDR_W:0] ae_level_i,
    output logic            full_o,
    output logic            empty_o,
    output logic            almost_full_o,
    output logic            almost_empty_o,
    output logic [ADDR_W:0] count_o
);

    logic idx_eq_s;
    logic tog_eq_s;

    // Modulo subtraction of the toggle-extended pointers gives 0..DEPTH directly.
    always_comb begin
        idx_eq_s       = (head_i[ADDR_W-1:0] == tail_i[ADDR_W-1:0]);
        tog_eq_s       = (head_i[ADDR_W] == tail_i[ADDR_W]);
        count_o        = tail_i - head_i;
        empty_o        = idx_eq_s && tog_eq_s;
        full_o         = idx_eq_s && !tog_eq_s;
        almost_full_o  = (count_o >= af_level_i);
        almost_empty_o = (count_o <= ae_level_i);
    end

endmodule

// File: rtl/rcv_fifo_param.sv
// Receive FIFO for the UART rcv path: stores each word with its framing-error
// bit, first-word fall-through read, sticky overrun/underrun errors.
module rcv_fifo_param
    import rcv_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned AF_LEVEL = 3,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_frame_err,
    input  logic              r_enable,
    input  logic              clear_errors,
    output logic [DATA_W-1:0] r_data,
    output logic              r_frame_err,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overrun_error,
    output logic              underrun_error
);

    localparam int unsigned     PTR_W  = ADDR_W + 1;
    localparam int unsigned     DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_LVL = PTR_W'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL = PTR_W'(AE_LEVEL);

    typedef struct packed {
        logic              frame_err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head_entry_s;
    logic [ADDR_W:0] head_q;
    logic [ADDR_W:0] head_d;
    logic [ADDR_W:0] tail_q;
    logic [ADDR_W:0] tail_d;
    logic            ovr_q;
    logic            ovr_d;
    logic            und_q;
    logic            und_d;
    logic            push_s;
    logic            pop_s;
    logic            ovr_ev_s;
    logic            und_ev_s;

    // Flag and count decode from the registered pointers.
    rcv_fifo_flags #(
        .ADDR_W (ADDR_W)
    ) u_flags (
        .head_i         (head_q),
        .tail_i         (tail_q),
        .af_level_i     (AF_LVL),
        .ae_level_i     (AE_LVL),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count)
    );

    // Accept decisions; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        push_s   = w_enable && (!full || r_enable);
        pop_s    = r_enable && !empty;
        ovr_ev_s = w_enable && full && !r_enable;
        und_ev_s = r_enable && empty && !w_enable;
    end

    // Next-state pointers and sticky errors; a new error event beats clear_errors.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        ovr_d  = ovr_q;
        und_d  = und_q;
        if (pop_s) begin
            head_d = PTR_W'(ptr_inc(PTR_MAX_W'(head_q), ADDR_W));
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = PTR_W'(ptr_inc(PTR_MAX_W'(tail_q), ADDR_W));
        end else begin
            tail_d = tail_q;
        end
        if (ovr_ev_s) begin
            ovr_d = 1'b1;
        end else if (clear_errors) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (und_ev_s) begin
            und_d = 1'b1;
        end else if (clear_errors) begin
            und_d = 1'b0;
        end else begin
            und_d = und_q;
        end
    end

    // Pointer and error state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            ovr_q  <= 1'b0;
            und_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovr_q  <= ovr_d;
            und_q  <= und_d;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[tail_q[ADDR_W-1:0]] <= '{frame_err: w_frame_err, data: w_data};
        end
    end

    // First-word fall-through read of the head entry.
    always_comb begin
        head_entry_s   = mem_q[head_q[ADDR_W-1:0]];
        r_data         = head_entry_s.data;
        r_frame_err    = head_entry_s.frame_err;
        overrun_error  = ovr_q;
        underrun_error = und_q;
    end

endmodule

// File: tb/tb_rcv_fifo_param.sv
// Randomised self-checking bench for rcv_fifo_param against a queue model.
module tb_rcv_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default configuration (depth 4, AF 3, AE 1)
    logic       rst, w_en, w_fe, r_en, clr;
    logic [7:0] w_dat, r_dat;
    logic       r_fe, full, empty, af, ae, ovr, und;
    logic [2:0] cnt;

    // DUT B: depth 8, AF 6, AE 2
    logic       b_rst, b_w_en, b_w_fe, b_r_en, b_clr;
    logic [7:0] b_w_dat, b_r_dat;
    logic       b_r_fe, b_full, b_empty, b_af, b_ae, b_ovr, b_und;
    logic [3:0] b_cnt;

    logic [8:0] mq[$];
    logic       m_ovr, m_und;
    logic [8:0] mqb[$];
    logic       mb_ovr, mb_und;
    int         n_cmp = 0;
    int         n_err = 0;

    rcv_fifo_param #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
        .clk(clk), .rst(rst), .w_enable(w_en), .w_data(w_dat), .w_frame_err(w_fe),
        .r_enable(r_en), .clear_errors(clr), .r_data(r_dat), .r_frame_err(r_fe),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
        .count(cnt), .overrun_error(ovr), .underrun_error(und)
    );

    rcv_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
        .clk(clk), .rst(b_rst), .w_enable(b_w_en), .w_data(b_w_dat), .w_frame_err(b_w_fe),
        .r_enable(b_r_en), .clear_errors(b_clr), .r_data(b_r_dat), .r_frame_err(b_r_fe),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_cnt), .overrun_error(b_ovr), .underrun_error(b_und)
    );

    // One clock on DUT A, with the queue model advanced by the FIFO rules.
    task automatic step(input logic w, input logic [7:0] d, input logic fe,
                        input logic r, input logic c, input logic rs);
        logic       full_m, empty_m;
        logic [8:0] tmp;
        rst = rs; w_en = w; w_dat = d; w_fe = fe; r_en = r; clr = c;
        full_m  = (mq.size() == 4);
        empty_m = (mq.size() == 0);
        @(posedge clk);
        if (rs) begin
            mq.delete(); m_ovr = 1'b0; m_und = 1'b0;
        end else begin
            if (r && !empty_m) tmp = mq.pop_front();
            if (w && (!full_m || r)) mq.push_back({fe, d});
            if (w && full_m && !r) m_ovr = 1'b1; else if (c) m_ovr = 1'b0;
            if (r && empty_m && !w) m_und = 1'b1; else if (c) m_und = 1'b0;
        end
        #1;
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr = 1'b0; w_fe = 1'b0; w_dat = 8'h00;
    endtask

    task automatic stepb(input logic w, input logic [7:0] d, input logic fe,
                         input logic r, input logic c, input logic rs);
        logic       full_m, empty_m;
        logic [8:0] tmp;
        b_rst = rs; b_w_en = w; b_w_dat = d; b_w_fe = fe; b_r_en = r; b_clr = c;
        full_m  = (mqb.size() == 8);
        empty_m = (mqb.size() == 0);
        @(posedge clk);
        if (rs) begin
            mqb.delete(); mb_ovr = 1'b0; mb_und = 1'b0;
        end else begin
            if (r && !empty_m) tmp = mqb.pop_front();
            if (w && (!full_m || r)) mqb.push_back({fe, d});
            if (w && full_m && !r) mb_ovr = 1'b1; else if (c) mb_ovr = 1'b0;
            if (r && empty_m && !w) mb_und = 1'b1; else if (c) mb_und = 1'b0;
        end
        #1;
        b_rst = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0; b_clr = 1'b0; b_w_fe = 1'b0; b_w_dat = 8'h00;
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", cnt); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", full); end
        n_cmp++; if (ae !== 1'b1 || af !== 1'b0) begin n_err++; $display("FAIL reset_ae_af: got %b%b exp 10", ae, af); end
        n_cmp++; if (ovr !== 1'b0 || und !== 1'b0) begin n_err++; $display("FAIL reset_errs: got %b%b exp 00", ovr, und); end
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b exp 0", empty); end
        n_cmp++; if (cnt !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d exp 1", cnt); end
        n_cmp++; if (r_dat !== 8'hA5 || r_fe !== 1'b0) begin n_err++; $display("FAIL single_data: got %h/%b exp a5/0", r_dat, r_fe); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty: got %b exp 1", empty); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        logic [3:0] fes;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        fes  = 4'b0010;
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], fes[i], 1'b0, 1'b0, 1'b0);
        n_cmp++; if (full !== 1'b1 || cnt !== 3'd4 || af !== 1'b1) begin
            n_err++; $display("FAIL fill_flags: got full=%b count=%0d af=%b exp 1/4/1", full, cnt, af); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (r_dat !== vals[i] || r_fe !== fes[i]) begin
                n_err++; $display("FAIL drain_order[%0d]: got %h/%b exp %h/%b", i, r_dat, r_fe, vals[i], fes[i]); end
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b exp 1", empty); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 84)), 1'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (cnt !== 3'd4) begin n_err++; $display("FAIL ovr_count: got %0d exp 4", cnt); end
        n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b exp 1", ovr); end
        // a second overrun together with clear_errors must leave the bit set
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (ovr !== m_ovr) begin n_err++; $display("FAIL ovr_set_wins: got %b exp %b", ovr, m_ovr); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (r_dat !== mq[0][7:0] || r_fe !== mq[0][8]) begin
                n_err++; $display("FAIL ovr_drain[%0d]: got %h/%b exp %h/%b", i, r_dat, r_fe, mq[0][7:0], mq[0][8]); end
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovr_drain_empty: got %b exp 1", empty); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b exp 0", ovr); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
            d = (p == 0) ? 8'h66 : 8'($urandom);
            step(1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (full !== 1'b1 || cnt !== 3'd4) begin
                n_err++; $display("FAIL fpp_full[%0d]: got full=%b count=%0d exp 1/4", p, full, cnt); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (r_dat !== mq[0][7:0] || r_fe !== mq[0][8]) begin
                    n_err++; $display("FAIL fpp_drain[%0d.%0d]: got %h/%b exp %h/%b", p, i, r_dat, r_fe, mq[0][7:0], mq[0][8]); end
                if (i == 3) begin
                    n_cmp++; if (r_dat !== d) begin n_err++; $display("FAIL fpp_last[%0d]: got %h exp %h", p, r_dat, d); end
                end
                step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            n_cmp++; if (empty !== 1'b1 || cnt !== 3'd0) begin
                n_err++; $display("FAIL fpp_empty[%0d]: got empty=%b count=%0d exp 1/0", p, empty, cnt); end
        end
    endtask

    task automatic test_underrun();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (und !== 1'b1 || cnt !== 3'd0) begin n_err++; $display("FAIL und_set: got und=%b count=%0d exp 1/0", und, cnt); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (und !== 1'b0) begin n_err++; $display("FAIL und_clear: got %b exp 0", und); end
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (cnt !== 3'd1 || und !== 1'b0) begin n_err++; $display("FAIL und_push_pop: got count=%0d und=%b exp 1/0", cnt, und); end
        n_cmp++; if (r_dat !== 8'h77) begin n_err++; $display("FAIL und_push_data: got %h exp 77", r_dat); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (und !== 1'b1) begin n_err++; $display("FAIL und_set_wins: got %b exp 1", und); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (cnt !== 3'd3 || und !== 1'b1) begin n_err++; $display("FAIL rst_pre: got count=%0d und=%b exp 3/1", cnt, und); end
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (cnt !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_state: got count=%0d empty=%b exp 0/1", cnt, empty); end
        n_cmp++; if (ovr !== 1'b0 || und !== 1'b0) begin n_err++; $display("FAIL rst_mid_errs: got %b%b exp 00", ovr, und); end
    endtask

    task automatic test_random();
        int sz;
        for (int i = 0; i < 400; i++) begin
            // write-biased first half, read-biased second half, so both ends get hit
            step(1'($urandom_range(0, 99) < ((i < 200) ? 70 : 30)), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 99) < ((i < 200) ? 30 : 70)), 1'($urandom_range(0, 99) < 8), 1'b0);
            sz = mq.size();
            n_cmp++; if (cnt !== 3'(sz)) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", i, cnt, sz); end
            n_cmp++; if (empty !== (sz == 0) || full !== (sz == 4)) begin
                n_err++; $display("FAIL rnd_ef[%0d]: got %b%b exp %b%b", i, empty, full, sz == 0, sz == 4); end
            n_cmp++; if (af !== (sz >= 3) || ae !== (sz <= 1)) begin
                n_err++; $display("FAIL rnd_afae[%0d]: got %b%b exp %b%b", i, af, ae, sz >= 3, sz <= 1); end
            n_cmp++; if (ovr !== m_ovr || und !== m_und) begin
                n_err++; $display("FAIL rnd_errs[%0d]: got %b%b exp %b%b", i, ovr, und, m_ovr, m_und); end
            if (sz > 0) begin
                n_cmp++; if (r_dat !== mq[0][7:0] || r_fe !== mq[0][8]) begin
                    n_err++; $display("FAIL rnd_head[%0d]: got %h/%b exp %h/%b", i, r_dat, r_fe, mq[0][7:0], mq[0][8]); end
            end
        end
    endtask

    task automatic test_cfg2();
        int sz;
        stepb(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (b_cnt !== 4'd0 || b_empty !== 1'b1 || b_ae !== 1'b1 || b_af !== 1'b0) begin
            n_err++; $display("FAIL cfg2_reset: got count=%0d empty=%b ae=%b af=%b", b_cnt, b_empty, b_ae, b_af); end
        for (int i = 0; i < 216; i++) begin
            if (i < 8) stepb(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
            else if (i < 16) stepb(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            else stepb(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom),
                       1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8), 1'b0);
            sz = mqb.size();
            n_cmp++; if (b_cnt !== 4'(sz) || b_full !== (sz == 8) || b_empty !== (sz == 0)) begin
                n_err++; $display("FAIL cfg2_count[%0d]: got %0d f=%b e=%b exp %0d", i, b_cnt, b_full, b_empty, sz); end
            n_cmp++; if (b_af !== (sz >= 6) || b_ae !== (sz <= 2)) begin
                n_err++; $display("FAIL cfg2_afae[%0d]: got %b%b exp %b%b at count %0d", i, b_af, b_ae, sz >= 6, sz <= 2, sz); end
            n_cmp++; if (b_ovr !== mb_ovr || b_und !== mb_und) begin
                n_err++; $display("FAIL cfg2_errs[%0d]: got %b%b exp %b%b", i, b_ovr, b_und, mb_ovr, mb_und); end
            if (sz > 0) begin
                n_cmp++; if (b_r_dat !== mqb[0][7:0] || b_r_fe !== mqb[0][8]) begin
                    n_err++; $display("FAIL cfg2_head[%0d]: got %h/%b exp %h/%b", i, b_r_dat, b_r_fe, mqb[0][7:0], mqb[0][8]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; w_en = 1'b0; w_fe = 1'b0; r_en = 1'b0; clr = 1'b0; w_dat = 8'h00;
        b_rst = 1'b1; b_w_en = 1'b0; b_w_fe = 1'b0; b_r_en = 1'b0; b_clr = 1'b0; b_w_dat = 8'h00;
        m_ovr = 1'b0; m_und = 1'b0; mb_ovr = 1'b0; mb_und = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_overrun();
        test_full_push_pop();
        test_underrun();
        test_rst_mid();
        test_random();
        test_cfg2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
